dac_mix_ds: RTL and testbench

Multi-channel audio mixer and delta-sigma DAC for mapper expansion audio. Each sample strobe snapshots `CH` unsigned channel levels and mixes them through a single time-multiplexed multiply-accumulate using per-channel gains. The mix is scaled by the master volume and saturated. A delta-sigma modulator running on every `clk` turns the held sample into the 1-bit `snd` (pwm) output. It is the parametrised successor to the single-channel first-order DAC used by expansion-audio mappers.

---
 rtl/dac_mix_pkg.sv | 18 +
 rtl/dac_ds_mod.sv | 55 +++++
 rtl/dac_mix_ds.sv | 129 ++++++++++++
 tb/tb_dac_mix_ds.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_mix_pkg.sv
// rtl/dac_mix_pkg.sv - sequencer states, unity/scale constants and accumulator width helper for dac_mix_ds
package dac_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2
    } state_e;

    localparam int GAIN_UNITY  = 128;
    // Channel gain and master volume both use 128 as unity, so one shift removes both.
    localparam int SCALE_SHIFT = 2 * $clog2(GAIN_UNITY);

    function automatic int acc_width(input int depth, input int ch);
        return depth + 8 + $clog2(ch);
    endfunction

endpackage

// File: rtl/dac_ds_mod.sv
// rtl/dac_ds_mod.sv - delta-sigma modulator, first order by default, second order with DAC_MIX_DS_ORDER2_EN
module dac_ds_mod #(
    parameter int MIX_W = 13
) (
    input  logic             clk,
    input  logic             map_rst,
    input  logic [MIX_W-1:0] sample,
    output logic             snd
);
`ifdef DAC_MIX_DS_ORDER2_EN
    localparam int A_W = MIX_W + 4;
`else
    localparam int A_W = MIX_W + 2;
`endif
    localparam logic signed [A_W-1:0] FS = A_W'(64'd1 << MIX_W);

    logic signed [A_W-1:0] smp_s;
    logic signed [A_W-1:0] fb;
    logic signed [A_W-1:0] a1_q, a1_d;
    logic                  q;
    logic                  snd_q;

    assign smp_s = signed'(A_W'(sample));
    assign fb    = q ? FS : '0;
    assign a1_d  = a1_q + smp_s - fb;

`ifdef DAC_MIX_DS_ORDER2_EN
    logic signed [A_W-1:0] a2_q, a2_d;

    assign q    = ~a2_q[A_W-1];
    assign a2_d = a2_q + a1_q - fb;
`else
    assign q = ~a1_q[A_W-1];
`endif

    // Integrators start at -1 so a zero sample is silent from the first cycle.
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            a1_q  <= '1;
            snd_q <= 1'b0;
`ifdef DAC_MIX_DS_ORDER2_EN
            a2_q  <= '1;
`endif
        end else begin
            a1_q  <= a1_d;
            snd_q <= q;
`ifdef DAC_MIX_DS_ORDER2_EN
            a2_q  <= a2_d;
`endif
        end
    end

    assign snd = snd_q;

endmodule

// File: rtl/dac_mix_ds.sv
// rtl/dac_mix_ds.sv - CH-channel MAC mixer with master volume feeding a delta-sigma DAC (order via DAC_MIX_DS_ORDER2_EN)
module dac_mix_ds
    import dac_mix_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DEPTH = 11,
    parameter int MIX_W = DEPTH + 2
) (
    input  logic                clk,
    input  logic                map_rst,
    input  logic                smp_stb,
    input  logic [CH*DEPTH-1:0] vol_in,
    input  logic [CH*8-1:0]     ch_gain,
    input  logic [7:0]          master_vol,
    output logic [MIX_W-1:0]    mix_out,
    output logic                busy,
    output logic                ovr,
    output logic                snd
);
    localparam int ACC_W = acc_width(DEPTH, CH);
    localparam int MUL_W = ACC_W + 8;
    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);
    localparam logic [MUL_W-1:0] MIX_MAX  = MUL_W'((64'd1 << MIX_W) - 64'd1);

    state_e              state_q, state_d;
    logic [CH*DEPTH-1:0] vol_q;
    logic [CH*8-1:0]     gain_q;
    logic [7:0]          mvol_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic                ovr_q, ovr_d;
    logic                accept;
    logic                load_mix;
    logic [ACC_W-1:0]    mul_a;
    logic [7:0]          mul_b;
    logic [MUL_W-1:0]    mul_p;
    logic [MUL_W-1:0]    scaled;

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (smp_stb) state_d = MAC;
            MAC:     if (idx_q == LAST_IDX) state_d = SCALE;
            SCALE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The one multiplier serves vol*gain during MAC and acc*master during SCALE.
    always_comb begin
        busy     = (state_q != IDLE);
        accept   = (state_q == IDLE) && smp_stb;
        load_mix = (state_q == SCALE);
        mul_a    = ACC_W'(vol_q[int'(idx_q)*DEPTH +: DEPTH]);
        mul_b    = gain_q[int'(idx_q)*8 +: 8];
        if (state_q == SCALE) begin
            mul_a = acc_q;
            mul_b = mvol_q;
        end
    end

    assign mul_p  = MUL_W'(mul_a) * MUL_W'(mul_b);
    assign scaled = mul_p >> SCALE_SHIFT;

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        mix_d = mix_q;
        ovr_d = ovr_q;
        if (smp_stb && busy) begin
            ovr_d = 1'b1;
        end
        if (accept) begin
            acc_d = '0;
            idx_d = '0;
        end else if (state_q == MAC) begin
            acc_d = acc_q + mul_p[ACC_W-1:0];
            idx_d = idx_q + 1'b1;
        end
        if (load_mix) begin
            mix_d = (scaled > MIX_MAX) ? {MIX_W{1'b1}} : scaled[MIX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            vol_q  <= '0;
            gain_q <= '0;
            mvol_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            mix_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (accept) begin
                vol_q  <= vol_in;
                gain_q <= ch_gain;
                mvol_q <= master_vol;
            end
            acc_q <= acc_d;
            idx_q <= idx_d;
            mix_q <= mix_d;
            ovr_q <= ovr_d;
        end
    end

    assign mix_out = mix_q;
    assign ovr     = ovr_q;

    dac_ds_mod #(
        .MIX_W (MIX_W)
    ) u_mod (
        .clk     (clk),
        .map_rst (map_rst),
        .sample  (mix_q),
        .snd     (snd)
    );

endmodule

// File: tb/tb_dac_mix_ds.sv
// tb/tb_dac_mix_ds.sv - randomized self-checking bench for dac_mix_ds against an arithmetic mix/density model
`timescale 1ns/1ps
module tb_dac_mix_ds;
    localparam int CH    = 4;
    localparam int DEPTH = 11;
    localparam int MIX_W = 13;
    localparam int FS    = 8192;
`ifdef DAC_MIX_DS_ORDER2_EN
    localparam int DENS_TOL = 2;
`else
    localparam int DENS_TOL = 1;
`endif

    logic                clk = 1'b0;
    logic                map_rst = 1'b0;
    logic                smp_stb = 1'b0;
    logic [CH*DEPTH-1:0] vol_in = '0;
    logic [CH*8-1:0]     ch_gain = '0;
    logic [7:0]          master_vol = '0;
    logic [MIX_W-1:0]    mix_out;
    logic                busy;
    logic                ovr;
    logic                snd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_mix_ds #(
        .CH    (CH),
        .DEPTH (DEPTH),
        .MIX_W (MIX_W)
    ) dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .smp_stb    (smp_stb),
        .vol_in     (vol_in),
        .ch_gain    (ch_gain),
        .master_vol (master_vol),
        .mix_out    (mix_out),
        .busy       (busy),
        .ovr        (ovr),
        .snd        (snd)
    );

    function automatic logic [MIX_W-1:0] ref_mix(input logic [CH*DEPTH-1:0] v,
                                                 input logic [CH*8-1:0] g,
                                                 input logic [7:0] m);
        longint acc = 0;
        longint s;
        for (int c = 0; c < CH; c++)
            acc += longint'(v[c*DEPTH +: DEPTH]) * longint'(g[c*8 +: 8]);
        s = (acc * longint'(m)) / 16384;
        if (s > FS - 1) s = FS - 1;
        return MIX_W'(s);
    endfunction

    task automatic rand_inputs(input int vmin, input int vmax, input int gmin, input int gmax,
                               input int mmin, input int mmax);
        for (int c = 0; c < CH; c++) begin
            vol_in[c*DEPTH +: DEPTH] = DEPTH'($urandom_range(vmax, vmin));
            ch_gain[c*8 +: 8]        = 8'($urandom_range(gmax, gmin));
        end
        master_vol = 8'($urandom_range(mmax, mmin));
    endtask

    task automatic pulse_stb();
        @(negedge clk);
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (snd === 1'b1) ones++;
        end
    endtask

    task automatic test_reset();
        int ones;
        smp_stb = 1'b0;
        vol_in = '0;
        ch_gain = '0;
        master_vol = '0;
        @(negedge clk);
        #2 map_rst = 1'b1;
        #1;
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL reset_mix: got %0d want 0", mix_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        n_cmp++; if (snd !== 1'b0) begin n_err++; $display("FAIL reset_snd: got %b want 0", snd); end
        @(negedge clk);
        map_rst = 1'b0;
        count_ones(64, ones);
        n_cmp++; if (ones !== 0) begin n_err++; $display("FAIL reset_silence: got %0d ones want 0", ones); end
    endtask

    task automatic test_single();
        int cyc, ones, d;
        logic [MIX_W-1:0] exp_mix;
        vol_in = '0;
        ch_gain = '0;
        vol_in[DEPTH-1:0] = 11'd1024;
        ch_gain[7:0] = 8'd128;
        master_vol = 8'd128;
        exp_mix = ref_mix(vol_in, ch_gain, master_vol);
        pulse_stb();
        wait_idle(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", cyc); end
        n_cmp++; if (mix_out !== exp_mix) begin n_err++; $display("FAIL single_mix: got %0d want %0d", mix_out, exp_mix); end
        repeat (16) @(negedge clk);
        count_ones(FS, ones);
        d = ones - int'(exp_mix);
        n_cmp++; if (d > DENS_TOL || d < -DENS_TOL) begin n_err++; $display("FAIL single_density: got %0d ones want %0d", ones, exp_mix); end
    endtask

    task automatic test_random_mix();
        int cyc, ones, d;
        logic [MIX_W-1:0] exp_mix;
        for (int t = 0; t < 8; t++) begin
            rand_inputs(0, 2047, 0, 255, 0, 255);
            exp_mix = ref_mix(vol_in, ch_gain, master_vol);
            pulse_stb();
            rand_inputs(0, 2047, 0, 255, 0, 255);
            wait_idle(cyc);
            n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 5", t, cyc); end
            n_cmp++; if (mix_out !== exp_mix) begin n_err++; $display("FAIL rand_mix[%0d]: got %0d want %0d", t, mix_out, exp_mix); end
            if (t < 2) begin
                repeat (16) @(negedge clk);
                count_ones(FS, ones);
                d = ones - int'(exp_mix);
                n_cmp++; if (d > DENS_TOL || d < -DENS_TOL) begin n_err++; $display("FAIL rand_density[%0d]: got %0d ones want %0d", t, ones, exp_mix); end
            end
        end
    endtask

    task automatic test_saturation();
        int cyc, ones;
        for (int c = 0; c < CH; c++) begin
            vol_in[c*DEPTH +: DEPTH] = 11'd2047;
            ch_gain[c*8 +: 8] = 8'd255;
        end
        master_vol = 8'd255;
        pulse_stb();
        wait_idle(cyc);
        n_cmp++; if (mix_out !== 13'd8191) begin n_err++; $display("FAIL sat_mix: got %0d want 8191", mix_out); end
        repeat (16) @(negedge clk);
        count_ones(FS, ones);
        n_cmp++; if (FS - ones > 1) begin n_err++; $display("FAIL sat_density: got %0d zeros want <=1", FS - ones); end
    endtask

    task automatic test_mute();
        int cyc, ones;
        rand_inputs(100, 2047, 1, 255, 0, 0);
        pulse_stb();
        wait_idle(cyc);
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL mute_mix: got %0d want 0", mix_out); end
        repeat (8) @(negedge clk);
        count_ones(256, ones);
        n_cmp++; if (ones !== 0) begin n_err++; $display("FAIL mute_snd: got %0d ones want 0", ones); end
    endtask

    task automatic test_overrun();
        int cyc;
        logic [MIX_W-1:0] exp1, exp2;
        @(negedge clk);
        map_rst = 1'b1;
        @(negedge clk);
        map_rst = 1'b0;
        rand_inputs(0, 300, 128, 160, 128, 128);
        vol_in[DEPTH-1:0] = DEPTH'($urandom_range(2047, 0));
        exp1 = ref_mix(vol_in, ch_gain, master_vol);
        @(negedge clk);
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        vol_in[DEPTH-1:0] = ~vol_in[DEPTH-1:0];
        exp2 = ref_mix(vol_in, ch_gain, master_vol);
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_on_accept: got %b want 0", ovr); end
        @(negedge clk);
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ovr); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovr_busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_done: busy got %b want 0", busy); end
        n_cmp++; if (mix_out !== exp1) begin n_err++; $display("FAIL ovr_first_mix: got %0d want %0d", mix_out, exp1); end
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovr_next_accept: busy got %b want 1", busy); end
        wait_idle(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL ovr_next_latency: got %0d want 5", cyc); end
        n_cmp++; if (mix_out !== exp2) begin n_err++; $display("FAIL ovr_second_mix: got %0d want %0d", mix_out, exp2); end
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
    endtask

    task automatic test_reset_mid_mac();
        int cyc;
        logic [MIX_W-1:0] exp_mix;
        rand_inputs(0, 1023, 128, 255, 128, 200);
        vol_in[DEPTH-1:0] = DEPTH'($urandom_range(1023, 512));
        exp_mix = ref_mix(vol_in, ch_gain, master_vol);
        pulse_stb();
        wait_idle(cyc);
        n_cmp++; if (mix_out !== exp_mix) begin n_err++; $display("FAIL midmac_pre_mix: got %0d want %0d", mix_out, exp_mix); end
        rand_inputs(0, 2047, 0, 255, 0, 255);
        pulse_stb();
        @(posedge clk);
        #2 map_rst = 1'b1;
        #1;
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL midmac_mix: got %0d want 0", mix_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midmac_busy: got %b want 0", busy); end
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL midmac_ovr: got %b want 0", ovr); end
        @(negedge clk);
        map_rst = 1'b0;
        rand_inputs(0, 2047, 0, 255, 0, 255);
        exp_mix = ref_mix(vol_in, ch_gain, master_vol);
        pulse_stb();
        wait_idle(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL midmac_latency: got %0d want 5", cyc); end
        n_cmp++; if (mix_out !== exp_mix) begin n_err++; $display("FAIL midmac_post_mix: got %0d want %0d", mix_out, exp_mix); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_mix();
        test_saturation();
        test_mute();
        test_overrun();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
